// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the planned receiver:
// parity-mode codes, the frame state encoding and the bit-period divider.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    // Clocks per line bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_frame_baud_tick.sv
// Bit-period timer: counts clocks while clr is low and emits a one-cycle
// tick on the last clock of every DIV-clock period. Shared with the receiver.
module uart_baud_tick #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    // Hold at zero while cleared, otherwise count and wrap after the tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a valid/ready byte input.
// Optional build macro UART_TX_FIFO_EN inserts a FIFO_DEPTH-entry input
// FIFO between the stream and the frame sequencer.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              uart_tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    if (DATA_W < 5 || DATA_W > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
        DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $fatal(1, "uart_tx_frame: illegal parameter combination");
    end

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;

    logic              baud_tick;
    logic              last_stop;
    logic              load_slot;
    logic              load;
    logic [DATA_W-1:0] load_data;

    uart_baud_tick #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state_q == ST_IDLE),
        .tick (baud_tick)
    );

    // The final clock of the last stop bit doubles as a load slot so a
    // waiting word starts its frame with no idle gap.
    assign last_stop = (state_q == ST_STOP) && baud_tick && (cnt_q == 4'(STOP_BITS - 1));
    assign load_slot = (state_q == ST_IDLE) || last_stop;
    assign tx_done   = last_stop;
    assign uart_tx   = tx_q;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_wr;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == (AW + 1)'(FIFO_DEPTH));
    assign load       = load_slot && !fifo_empty;
    assign load_data  = fifo_mem[rd_ptr_q[AW-1:0]];
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign s_ready    = !fifo_full || load;
    assign fifo_wr    = s_valid && s_ready;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

    // Pointer advance on write and on pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(fifo_wr);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(load);
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= s_data;
        end
    end
`else
    assign s_ready   = load_slot;
    assign load      = s_valid && load_slot;
    assign load_data = s_data;
    assign busy      = (state_q != ST_IDLE);
`endif

    // Frame sequencer: advances one line bit per baud tick; a load
    // overrides everything and starts a fresh frame on the next clock.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (cnt_q == 4'(DATA_W - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            ST_PAR: begin
                if (baud_tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (last_stop) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase
        if (load) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            shift_d = load_data;
            par_d   = (^load_data) ^ (PARITY == PAR_ODD);
            cnt_d   = '0;
        end
    end

    // Sequencer registers; reset drives the line high at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame. Several instances cover the default
// 8N1 build, even/odd parity, 7-bit/2-stop framing and (with
// UART_TX_FIFO_EN) a 4-deep input FIFO.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] vld;
    logic [7:0] sd [5];
    wire  [4:0] rdy, txw, bsy, dn;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    uart_tx_frame u_def (
        .clk(clk), .rstn(rstn), .s_data(sd[0]), .s_valid(vld[0]), .s_ready(rdy[0]),
        .uart_tx(txw[0]), .busy(bsy[0]), .tx_done(dn[0]));

    uart_tx_frame #(.CLK_FREQ(1000), .BAUD(100), .PARITY(2)) u_even (
        .clk(clk), .rstn(rstn), .s_data(sd[1]), .s_valid(vld[1]), .s_ready(rdy[1]),
        .uart_tx(txw[1]), .busy(bsy[1]), .tx_done(dn[1]));

    uart_tx_frame #(.CLK_FREQ(1000), .BAUD(100), .PARITY(1)) u_odd (
        .clk(clk), .rstn(rstn), .s_data(sd[2]), .s_valid(vld[2]), .s_ready(rdy[2]),
        .uart_tx(txw[2]), .busy(bsy[2]), .tx_done(dn[2]));

    uart_tx_frame #(.DATA_W(7), .STOP_BITS(2)) u_w7 (
        .clk(clk), .rstn(rstn), .s_data(sd[3][6:0]), .s_valid(vld[3]), .s_ready(rdy[3]),
        .uart_tx(txw[3]), .busy(bsy[3]), .tx_done(dn[3]));

    uart_tx_frame #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) u_fifo (
        .clk(clk), .rstn(rstn), .s_data(sd[4]), .s_valid(vld[4]), .s_ready(rdy[4]),
        .uart_tx(txw[4]), .busy(bsy[4]), .tx_done(dn[4]));

    // Single-bit comparison with reporting.
    task automatic cmp1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) $display("[TB] FAIL %s: got %b required %b", name, got, want);
        else passes++;
    endtask

    // Offer one word for a single clock, then scramble s_data.
    task automatic send_word(input int idx, input logic [7:0] w);
        @(negedge clk);
        sd[idx]  = w;
        vld[idx] = 1'b1;
        @(negedge clk);
        vld[idx] = 1'b0;
        sd[idx]  = ~w;
    endtask

    // Wait for a start bit, then check every clock of an nbits-period frame.
    task automatic check_frame(input int idx, input int div, input int nbits,
                               input logic [15:0] exp, input string name);
        int guard = 0;
        logic [15:0] bad = '0;
        logic [15:0] seen = '0;
        int busy_bad = 0;
        int done_cnt = 0;
        int done_at  = -1;
        while (txw[idx] !== 1'b0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            checks++;
            $display("[TB] FAIL %s start: got no start bit, required one within 5000 clks", name);
            return;
        end
        for (int c = 0; c < nbits * div; c++) begin
            if (txw[idx] !== exp[c / div] && !bad[c / div]) begin
                bad[c / div]  = 1'b1;
                seen[c / div] = txw[idx];
            end
            if (bsy[idx] !== 1'b1) busy_bad++;
            if (dn[idx] === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            @(negedge clk);
        end
        for (int b = 0; b < nbits; b++) begin
            checks++;
            if (bad[b]) $display("[TB] FAIL %s bit%0d: line got %b required %b", name, b, seen[b], exp[b]);
            else passes++;
        end
        checks++;
        if (done_cnt != 1 || done_at != nbits * div - 1)
            $display("[TB] FAIL %s tx_done: got %0d pulses at clk %0d, required 1 at clk %0d",
                     name, done_cnt, done_at, nbits * div - 1);
        else passes++;
        checks++;
        if (busy_bad != 0) $display("[TB] FAIL %s busy: got %0d low clks, required 0", name, busy_bad);
        else passes++;
    endtask

    task automatic test_reset();
        int stray = 0;
        rstn = 1'b0;
        vld  = '0;
        for (int i = 0; i < 5; i++) sd[i] = 8'h00;
        repeat (3) @(negedge clk);
        cmp1("rst_tx", txw[0], 1'b1);
        cmp1("rst_busy", bsy[0], 1'b0);
        cmp1("rst_done", dn[0], 1'b0);
        cmp1("rst_ready", rdy[0], 1'b1);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (txw !== 5'b11111 || bsy !== 5'b00000)
            $display("[TB] FAIL post_rst: got tx %b busy %b, required 11111 00000", txw, bsy);
        else passes++;
        repeat (20) begin
            @(negedge clk);
            if (txw[0] !== 1'b1 || bsy[0] !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) $display("[TB] FAIL idle_hold: got %0d non-idle clks, required 0", stray);
        else passes++;
    endtask

    task automatic test_8n1();
        send_word(0, 8'h55);
`ifdef UART_TX_FIFO_EN
        cmp1("latency_fifo", txw[0], 1'b1);
`else
        cmp1("latency", txw[0], 1'b0);
`endif
        check_frame(0, 434, 10, {6'b0, 1'b1, 8'h55, 1'b0}, "8n1_55");
        cmp1("8n1_idle_tx", txw[0], 1'b1);
        cmp1("8n1_idle_busy", bsy[0], 1'b0);
    endtask

    task automatic test_parity();
        send_word(1, 8'hA5);
        check_frame(1, 10, 11, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, "even_a5");
        send_word(2, 8'hA5);
        check_frame(2, 10, 11, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, "odd_a5");
        send_word(2, 8'h00);
        check_frame(2, 10, 11, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}, "odd_00");
    endtask

    task automatic test_w7_two_stop();
        send_word(3, 8'h7F);
        check_frame(3, 434, 10, {6'b0, 2'b11, 7'h7F, 1'b0}, "w7_7f");
        cmp1("w7_busy_after", bsy[3], 1'b0);
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_back_to_back();
        logic [7:0] words [3];
        int accepted = 0;
        int rdy_cycles = 0;
        int rdy_bad = 0;
        int guard = 0;
        words[0] = 8'h31;
        words[1] = 8'h32;
        words[2] = 8'h33;
        fork
            begin
                logic r;
                @(negedge clk);
                sd[0]  = words[0];
                vld[0] = 1'b1;
                while (accepted < 3 && guard < 20000) begin
                    r = rdy[0];
                    if (r === 1'b1) begin
                        rdy_cycles++;
                        if (accepted > 0 && dn[0] !== 1'b1) rdy_bad++;
                    end
                    @(negedge clk);
                    guard++;
                    if (r === 1'b1) begin
                        accepted++;
                        if (accepted < 3) sd[0] = words[accepted];
                        else vld[0] = 1'b0;
                    end
                end
                vld[0] = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    check_frame(0, 434, 10, {6'b0, 1'b1, words[k], 1'b0}, $sformatf("b2b_%0d", k));
                    if (k < 2) cmp1($sformatf("b2b_gap_%0d", k), txw[0], 1'b0);
                end
            end
        join
        checks++;
        if (rdy_cycles != 3 || guard >= 20000)
            $display("[TB] FAIL b2b_ready: got %0d ready clks, required 3", rdy_cycles);
        else passes++;
        checks++;
        if (rdy_bad != 0) $display("[TB] FAIL b2b_ready_done: got %0d ready clks without tx_done, required 0", rdy_bad);
        else passes++;
        cmp1("b2b_idle", txw[0], 1'b1);
    endtask
`endif

    task automatic test_reset_mid_frame();
        int guard = 0;
        int stray = 0;
        send_word(0, 8'hF0);
        while (txw[0] !== 1'b0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        repeat (434 + 434 + 200) @(negedge clk);
        cmp1("mid_pre_rst", txw[0], 1'b0);
        #2 rstn = 1'b0;
        #1;
        cmp1("mid_rst_tx", txw[0], 1'b1);
        cmp1("mid_rst_busy", bsy[0], 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (txw[0] !== 1'b1 || bsy[0] !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) $display("[TB] FAIL mid_abandon: got %0d non-idle clks, required 0", stray);
        else passes++;
        send_word(0, 8'h0F);
        check_frame(0, 434, 10, {6'b0, 1'b1, 8'h0F, 1'b0}, "after_rst_0f");
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo_burst();
        logic [7:0] words [6];
        int accepted = 0;
        int ready_low = 0;
        int guard = 0;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h3C;
        words[3] = 8'hA5; words[4] = 8'h5A; words[5] = 8'hFF;
        fork
            begin
                logic r;
                @(negedge clk);
                sd[4]  = words[0];
                vld[4] = 1'b1;
                while (accepted < 6 && guard < 5000) begin
                    r = rdy[4];
                    if (r !== 1'b1) ready_low++;
                    @(negedge clk);
                    guard++;
                    if (r === 1'b1) begin
                        accepted++;
                        if (accepted < 6) sd[4] = words[accepted];
                        else vld[4] = 1'b0;
                    end
                end
                vld[4] = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++)
                    check_frame(4, 10, 10, {6'b0, 1'b1, words[k], 1'b0}, $sformatf("fifo_%0d", k));
            end
        join
        checks++;
        if (accepted != 6) $display("[TB] FAIL fifo_accept: got %0d words, required 6", accepted);
        else passes++;
        checks++;
        if (ready_low == 0) $display("[TB] FAIL fifo_full: got 0 not-ready clks, required at least 1");
        else passes++;
        cmp1("fifo_busy_after", bsy[4], 1'b0);
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at 2 ms, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_w7_two_stop();
`ifdef UART_TX_FIFO_EN
        test_fifo_burst();
`else
        test_back_to_back();
`endif
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
